comb_feedback_stage: RTL and testbench
======================================

Name: comb_feedback_stage

Overview:
- Feedback comb filter core for the reverb path.
- Sits directly upstream of the fixed-length delay FIFO (LEN samples). It drives the FIFO's write data and shift-enable, and consumes the FIFO's tail output as the delayed term.
- Per input sample it computes y[n] = sat(x[n] + g·y[n−LEN]), emits y[n] downstream, and pushes y[n] into the FIFO.
- Three-state sequential datapath with a one-sample-in-flight handshake and overrun detection.

Parameters:
- WIDTH, 24, signed two's-complement sample width (x, y, FIFO data).
- GAIN_W, 16, signed feedback gain width.
- GAIN_FRAC, 15, fractional bits of gain (Q1.15 default; 0x4000 = 0.5).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- sample_valid  in  1  one-cycle strobe; sample_in is valid.
- sample_in  in  WIDTH  signed input sample x[n].
- gain  in  GAIN_W  signed feedback gain; sampled on accept.
- fifo_out  in  WIDTH  delayed sample y[n−LEN] from the FIFO tail.
- fifo_enable  out  1  one-cycle shift strobe to the FIFO.
- fifo_in  out  WIDTH  data pushed into the FIFO (= y[n]).
- sample_out  out  WIDTH  signed filtered sample y[n]; held until the next result.
- out_valid  out  1  one-cycle strobe; sample_out updated this cycle.
- busy  out  1  high while a sample is in flight.
- overrun  out  1  sticky flag: a sample_valid arrived while busy.
- clear_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset (async, rstn=0): state=IDLE; sample_out, fifo_in, all internal registers = 0; out_valid, fifo_enable, busy, overrun = 0. Takes effect immediately, independent of clk.
- FSM states: IDLE, MUL, ADD.
- IDLE: busy=0. On sample_valid, capture x←sample_in, d←fifo_out, g←gain, then go to MUL.
- MUL: busy=1. Register p = d·g as a full-precision signed product (WIDTH+GAIN_W bits), then go to ADD.
- ADD: busy=1.
  - s = sext(x) + (p >>> GAIN_FRAC): arithmetic shift, truncation toward −inf, evaluated at WIDTH+GAIN_W+1 bits (no intermediate overflow).
  - Saturate s to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Register the saturated value into sample_out and fifo_in.
  - Assert out_valid and fifo_enable together for exactly the next cycle, then return to IDLE.
- Latency: sample_valid at cycle T produces out_valid/fifo_enable high during cycle T+3. Throughput is at most one sample per 3 cycles; at the audio sample rate this is always met.
- fifo_out is sampled only in IDLE at accept. The FIFO shifts only after the sample is complete, so the read-before-write order is fixed.
- Effective loop delay is exactly LEN samples: the push from sample n is read by sample n+LEN.
- sample_valid while busy: the sample is dropped with no state change, and overrun is set.
- sample_valid in the same cycle out_valid is high: busy is 0 in that cycle, so the sample is accepted normally.
- overrun: set-dominant. If set and clear_overrun occur in the same cycle, overrun=1.
- Reset mid-operation (MUL or ADD): the in-flight sample is discarded and no fifo_enable is issued. FIFO contents are governed by the FIFO's own reset.
- gain=0: y=x exactly. gain negative: valid; result is saturated identically.
- out_valid and fifo_enable are never asserted outside the ADD→IDLE cycle.

Test Plan:
- gain=0, fifo_out=0x123456, sample_in=0x000100 strobed at cycle T -> out_valid only at T+3, sample_out=0x000100, fifo_in=0x000100, fifo_enable at T+3.
- gain=0x4000, fifo_out=0x000800, sample_in=0x000010 -> sample_out=0x000410. Repeat with fifo_out=0xFFFFFF (−1) -> sample_out=0x00000F (floor of −0.5 is −1).
- Saturation: x=0x7FFFFF, d=0x400000, g=0x4000 -> 0x7FFFFF. Then x=0x800000, d=0xC00000, g=0x4000 -> 0x800000.
- Overrun: strobe at T, again at T+1 -> single out_valid at T+3, overrun=1. Strobe with clear_overrun simultaneously asserted -> overrun stays 1. clear_overrun alone -> overrun=0.
- rstn low during MUL -> outputs zero immediately, no fifo_enable/out_valid follows. Next strobe after release -> normal 3-cycle result.
- Closed loop with the LEN=4 delay FIFO, g=0x4000, impulse x=1000 then zeros at 64-cycle spacing -> outputs 1000,0,0,0,500,0,0,0,250,…; FIFO receives exactly one fifo_enable per sample.

Source files
------------

// File: rtl/comb_feedback_stage.sv
// Feedback comb filter core: y[n] = sat(x[n] + g*y[n-LEN]), feeding and reading an external delay FIFO.
// One sample in flight; accept -> multiply -> add/saturate -> result strobe.
module comb_feedback_stage #(
  parameter int WIDTH     = 24,
  parameter int GAIN_W    = 16,
  parameter int GAIN_FRAC = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sample_valid,
  input  logic [WIDTH-1:0]  sample_in,
  input  logic [GAIN_W-1:0] gain,
  input  logic [WIDTH-1:0]  fifo_out,
  output logic              fifo_enable,
  output logic [WIDTH-1:0]  fifo_in,
  output logic [WIDTH-1:0]  sample_out,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun,
  input  logic              clear_overrun
);

  // state | meaning
  // IDLE  | waiting for sample_valid; fifo_out sampled on accept
  // MUL   | registering d*g at full precision
  // ADD   | scale, add x, saturate; result strobe follows
  typedef enum logic [1:0] {IDLE, MUL, ADD} state_t;

  localparam int PW = WIDTH + GAIN_W;
  localparam int SW = PW + 1;

  state_t                    state;
  logic signed [WIDTH-1:0]   x_r;
  logic signed [WIDTH-1:0]   d_r;
  logic signed [GAIN_W-1:0]  g_r;
  logic signed [PW-1:0]      p_r;
  logic signed [PW-1:0]      p_scaled;
  logic signed [SW-1:0]      sum;
  logic        [WIDTH-1:0]   sat;

  // Sum is one bit wider than the product so the add itself can never wrap.
  always_comb begin
    p_scaled = p_r >>> GAIN_FRAC;
    sum      = SW'(x_r) + SW'(p_scaled);
    sat      = sum[WIDTH-1:0];
    if (!sum[SW-1] && (sum[SW-2:WIDTH-1] != '0))
      sat = {1'b0, {(WIDTH-1){1'b1}}};
    else if (sum[SW-1] && (sum[SW-2:WIDTH-1] != '1))
      sat = {1'b1, {(WIDTH-1){1'b0}}};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      x_r         <= '0;
      d_r         <= '0;
      g_r         <= '0;
      p_r         <= '0;
      sample_out  <= '0;
      fifo_in     <= '0;
      out_valid   <= 1'b0;
      fifo_enable <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      fifo_enable <= 1'b0;
      // Set wins over clear when both happen in one cycle.
      if (clear_overrun)
        overrun <= 1'b0;
      if (sample_valid && busy)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            x_r   <= sample_in;
            d_r   <= fifo_out;
            g_r   <= gain;
            busy  <= 1'b1;
            state <= MUL;
          end
        end
        MUL: begin
          p_r   <= PW'(d_r) * PW'(g_r);
          state <= ADD;
        end
        ADD: begin
          sample_out  <= sat;
          fifo_in     <= sat;
          out_valid   <= 1'b1;
          fifo_enable <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comb_feedback_stage.sv
// Scoreboard bench for comb_feedback_stage: directed plan cases, random samples, and a closed loop
// through a LEN=4 delay FIFO model.
module tb_comb_feedback_stage;

  localparam int WIDTH = 24;
  localparam int GAIN_W = 16;
  localparam int LEN = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              sample_valid = 1'b0;
  logic [WIDTH-1:0]  sample_in = '0;
  logic [GAIN_W-1:0] gain = '0;
  logic [WIDTH-1:0]  fifo_out;
  logic [WIDTH-1:0]  fifo_drv = '0;
  logic              fifo_enable;
  logic [WIDTH-1:0]  fifo_in;
  logic [WIDTH-1:0]  sample_out;
  logic              out_valid;
  logic              busy;
  logic              overrun;
  logic              clear_overrun = 1'b0;

  comb_feedback_stage #(.WIDTH(WIDTH), .GAIN_W(GAIN_W), .GAIN_FRAC(15)) dut (
    .clk(clk), .rstn(rstn), .sample_valid(sample_valid), .sample_in(sample_in),
    .gain(gain), .fifo_out(fifo_out), .fifo_enable(fifo_enable), .fifo_in(fifo_in),
    .sample_out(sample_out), .out_valid(out_valid), .busy(busy), .overrun(overrun),
    .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int en_count = 0;
  logic loop_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Delay FIFO model: tail is the oldest of the last LEN pushes.
  logic [WIDTH-1:0] fq [LEN];
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LEN; i++) fq[i] <= '0;
    end else if (fifo_enable) begin
      en_count <= en_count + 1;
      fq[0] <= fifo_in;
      for (int i = 1; i < LEN; i++) fq[i] <= fq[i-1];
    end
  end
  assign fifo_out = loop_mode ? fq[LEN-1] : fifo_drv;

  typedef struct {
    logic [WIDTH-1:0] y;
    int               when;
  } exp_t;
  exp_t sb_q[$];

  function automatic logic [WIDTH-1:0] ref_y(logic signed [WIDTH-1:0] x,
                                             logic signed [WIDTH-1:0] d,
                                             logic signed [GAIN_W-1:0] g);
    longint p;
    longint s;
    p = longint'(d) * longint'(g);
    s = longint'(x) + (p >>> 15);
    if (s > 64'sd8388607) s = 64'sd8388607;
    if (s < -64'sd8388608) s = -64'sd8388608;
    return s[WIDTH-1:0];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: strobe pairing every cycle, result contents and timing on out_valid.
  always @(negedge clk) begin
    if (rstn) begin
      if (fifo_enable !== out_valid) begin
        checks++;
        errors++;
        $display("FAIL strobe_pair: fifo_enable=%0b out_valid=%0b (cycle %0d)", fifo_enable, out_valid, cyc);
      end
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: out_valid with nothing pending, sample_out=%0h (cycle %0d)", sample_out, cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sample_out", 32'(sample_out), 32'(e.y));
          check("fifo_in", 32'(fifo_in), 32'(e.y));
          check("latency", 32'(cyc), 32'(e.when));
        end
      end
    end
  end

  // Called just after a rising edge; strobe lasts one cycle.
  task automatic issue(logic [WIDTH-1:0] x, logic [WIDTH-1:0] d, logic [GAIN_W-1:0] g);
    exp_t e;
    sample_in = x;
    fifo_drv = d;
    gain = g;
    sample_valid = 1'b1;
    e.y = ref_y(x, d, g);
    e.when = cyc + 3;
    sb_q.push_back(e);
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] y_hist [$];
    logic [WIDTH-1:0] d_loop;

    #12;
    check("reset_sample_out", 32'(sample_out), 32'h0);
    check("reset_flags", {28'h0, out_valid, fifo_enable, busy, overrun}, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(2);

    // Directed cases from the plan.
    issue(24'h000100, 24'h123456, 16'h0000); idle(4);
    issue(24'h000010, 24'h000800, 16'h4000); idle(4);
    issue(24'h000010, 24'hFFFFFF, 16'h4000); idle(4);
    issue(24'h7FFFFF, 24'h400000, 16'h4000); idle(4);
    issue(24'h800000, 24'hC00000, 16'h4000); idle(4);
    issue(24'h000064, 24'h000200, 16'hC000); idle(2);
    // Back-to-back at the 3-cycle limit: strobe coincides with out_valid.
    issue(24'h000005, 24'h000006, 16'h8000); idle(2);
    check("no_overrun_at_limit", 32'(overrun), 32'h0);
    idle(4);

    // Overrun: second strobe one cycle later is dropped.
    issue(24'h000111, 24'h000222, 16'h2000);
    check("busy_in_flight", 32'(busy), 32'h1);
    sample_in = 24'h3FFFFF; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    idle(4);
    check("overrun_set", 32'(overrun), 32'h1);
    check("busy_idle", 32'(busy), 32'h0);

    // Set and clear together: set wins.
    issue(24'h000333, 24'h000000, 16'h0000);
    sample_valid = 1'b1; clear_overrun = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0; clear_overrun = 1'b0;
    idle(4);
    check("overrun_set_dominant", 32'(overrun), 32'h1);
    clear_overrun = 1'b1;
    @(posedge clk); #1;
    clear_overrun = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'h0);

    // Random samples with random spacing (>= 3 cycles).
    for (int i = 0; i < 40; i++) begin
      issue(WIDTH'($urandom), WIDTH'($urandom), GAIN_W'($urandom));
      idle(2 + $urandom_range(0, 3));
    end
    idle(4);

    // Reset while in MUL: outputs clear at once, no strobe follows.
    issue(24'h000ABC, 24'h000100, 16'h4000);
    #2 rstn = 1'b0;
    #1;
    sb_q.delete();
    check("rst_mul_sample_out", 32'(sample_out), 32'h0);
    check("rst_mul_flags", {28'h0, out_valid, fifo_enable, busy, overrun}, 32'h0);
    idle(2);
    rstn = 1'b1;
    idle(5);
    issue(24'h000042, 24'h000000, 16'h4000); idle(4);

    // Closed loop through the LEN=4 FIFO; fresh FIFO and history.
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(2);
    loop_mode = 1'b1;
    en_count = 0;
    for (int n = 0; n < 16; n++) begin
      exp_t e;
      d_loop = (n >= LEN) ? y_hist[n-LEN] : '0;
      sample_in = (n == 0) ? 24'd1000 : 24'd0;
      gain = 16'h4000;
      sample_valid = 1'b1;
      e.y = ref_y(sample_in, d_loop, 16'h4000);
      e.when = cyc + 3;
      y_hist.push_back(e.y);
      sb_q.push_back(e);
      @(posedge clk); #1;
      sample_valid = 1'b0;
      idle(63);
    end
    check("loop_tap4", 32'(y_hist[4]), 32'd500);
    check("loop_enables", 32'(en_count), 32'd16);
    loop_mode = 1'b0;

    idle(5);
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
